// File: rtl/mac_pkg.sv
// Shared definitions for the systolic matrix-multiply engine.
//   state_t : engine sequencing states
//   cnt_w   : width of the beat / flush step counter (holds up to 3N-1)
//   row_w   : width of the result row index
package mac_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, OUT} state_t;

    localparam int N_DEF      = 3;
    localparam int DW_DEF     = 5;
    localparam int ACC_W_DEF  = 2*DW_DEF + 4;
    localparam int SIGNED_DEF = 0;

    function automatic int cnt_w(input int n);
        return $clog2(3*n);
    endfunction

    function automatic int row_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mac_systolic_mm_if.sv
// Operand-in / result-out streaming bus of the systolic matrix-multiply engine.
//   in_valid/in_ready : operand beat handshake (a_col = column k of A, b_row = row k of B)
//   acc_keep          : with beat 0, add the tile onto the existing result
//   out_valid/out_ready : result row handshake (c_row = row out_row of C, out_last on row N-1)
//   busy              : engine is not idle
// master = operand/result producer-consumer side, slave = engine side.
interface mac_systolic_mm_if
    import mac_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DW    = DW_DEF,
    parameter int ACC_W = 2*DW + 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic [N-1:0][DW-1:0]        a_col;
    logic [N-1:0][DW-1:0]        b_row;
    logic                        acc_keep;
    logic                        out_valid;
    logic                        out_ready;
    logic [N-1:0][ACC_W-1:0]     c_row;
    logic [row_w(N)-1:0]         out_row;
    logic                        out_last;
    logic                        busy;

    modport master (
        output in_valid, a_col, b_row, acc_keep, out_ready,
        input  in_ready, out_valid, c_row, out_row, out_last, busy
    );

    modport slave (
        input  in_valid, a_col, b_row, acc_keep, out_ready,
        output in_ready, out_valid, c_row, out_row, out_last, busy
    );
endinterface

// File: rtl/mac_pe.sv
// One processing element of the output-stationary array.
//   clk, rst_n : clock, async active-low reset
//   step_en    : array advances one step this cycle
//   clr        : start a new sum (acc = product instead of acc + product)
//   a_in/b_in  : operands from the left / top neighbour
//   a_out/b_out: registered pass-through to the right / bottom neighbour
//   acc        : running dot product
module mac_pe
    import mac_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int ACC_W  = 2*DW + 4,
    parameter int SIGNED = SIGNED_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_en,
    input  logic             clr,
    input  logic [DW-1:0]    a_in,
    input  logic [DW-1:0]    b_in,
    output logic [DW-1:0]    a_out,
    output logic [DW-1:0]    b_out,
    output logic [ACC_W-1:0] acc
);
    localparam logic SX = (SIGNED != 0);

    logic [2*DW-1:0]  a_x, b_x, prod;
    logic [ACC_W-1:0] prod_x;

    // Extending both operands to 2*DW first makes the low 2*DW bits of the
    // product exact in either signedness.
    assign a_x    = {{DW{SX & a_in[DW-1]}}, a_in};
    assign b_x    = {{DW{SX & b_in[DW-1]}}, b_in};
    assign prod   = a_x * b_x;
    assign prod_x = {{(ACC_W-2*DW){SX & prod[2*DW-1]}}, prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (step_en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= (clr ? '0 : acc) + prod_x;
        end
    end
endmodule

// File: rtl/mac_systolic_mm.sv
// N x N output-stationary systolic matrix multiply, C = A.B (optionally C += A.B).
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of mac_systolic_mm_if (operand beats in, result rows out)
// Beat k carries column k of A and row k of B. Operands enter through
// triangular skew banks so PE(i,j) sees a[i][k], b[k][j] together at step
// k+i+j+1; 2N-1 zero-operand flush steps then complete the last product
// before rows are drained one per handshake.
module mac_systolic_mm
    import mac_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DW     = DW_DEF,
    parameter int ACC_W  = 2*DW + 4,
    parameter int SIGNED = SIGNED_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mac_systolic_mm_if.slave  bus
);
    localparam int CW = cnt_w(N);
    localparam int RW = row_w(N);

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [RW-1:0]           row, row_nxt;
    logic                    in_ready_q, out_valid_q, out_last_q;
    logic [N-1:0][ACC_W-1:0] c_q;

    logic                    fire, step_en, clr;
    logic [N-1:0][DW-1:0]    a_inj, b_inj, a_edge, b_edge;
    logic [DW-1:0]           a_h [N][N+1];
    logic [DW-1:0]           b_v [N+1][N];
    logic [ACC_W-1:0]        acc_m [N][N];
    logic [N-1:0]            unused_a, unused_b;

    // in_ready_q is only set in IDLE/LOAD, so fire implies one of those.
    assign fire    = bus.in_valid & in_ready_q;
    assign step_en = fire | (state == FLUSH);
    assign clr     = fire & (state == IDLE) & ~bus.acc_keep;
    assign a_inj   = (state == FLUSH) ? '0 : bus.a_col;
    assign b_inj   = (state == FLUSH) ? '0 : bus.b_row;

    // Skew banks: lane i delayed i steps. Lane 0 feeds the array directly.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        if (gi == 0) begin : g_direct
            assign a_edge[gi] = a_inj[gi];
            assign b_edge[gi] = b_inj[gi];
        end else begin : g_delay
            logic [gi-1:0][DW-1:0] a_sr, b_sr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_sr <= '0;
                    b_sr <= '0;
                end else if (step_en) begin
                    a_sr[0] <= a_inj[gi];
                    b_sr[0] <= b_inj[gi];
                    for (int d = 1; d < gi; d++) begin
                        a_sr[d] <= a_sr[d-1];
                        b_sr[d] <= b_sr[d-1];
                    end
                end
            end
            assign a_edge[gi] = a_sr[gi-1];
            assign b_edge[gi] = b_sr[gi-1];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        assign a_h[gi][0] = a_edge[gi];
        assign b_v[0][gi] = b_edge[gi];
        // Operands leaving the array edge go nowhere.
        assign unused_a[gi] = ^a_h[gi][N];
        assign unused_b[gi] = ^b_v[N][gi];
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            mac_pe #(.DW(DW), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_pe (
                .clk     (clk),
                .rst_n   (rst_n),
                .step_en (step_en),
                .clr     (clr),
                .a_in    (a_h[gi][gj]),
                .b_in    (b_v[gi][gj]),
                .a_out   (a_h[gi][gj+1]),
                .b_out   (b_v[gi+1][gj]),
                .acc     (acc_m[gi][gj])
            );
        end
    end

    assign row_nxt = row + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            row         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            c_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (fire) begin
                        state <= LOAD;
                        cnt   <= CW'(1);
                    end
                end
                LOAD: begin
                    if (fire) begin
                        if (cnt == CW'(N-1)) begin
                            state      <= FLUSH;
                            cnt        <= '0;
                            in_ready_q <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    cnt <= cnt + 1'b1;
                    // The final flush step adds only zero products, so row 0
                    // is already complete when captured here.
                    if (cnt == CW'(2*N-2)) begin
                        state       <= OUT;
                        cnt         <= '0;
                        row         <= '0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        for (int j = 0; j < N; j++) c_q[j] <= acc_m[0][j];
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        if (row == RW'(N-1)) begin
                            state       <= IDLE;
                            row         <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end else begin
                            row        <= row_nxt;
                            out_last_q <= (row_nxt == RW'(N-1));
                            for (int j = 0; j < N; j++) c_q[j] <= acc_m[row_nxt][j];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_row   = row;
    assign bus.c_row     = c_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mac_systolic_mm.sv
// Self-checking bench: three engines (3x3/5b unsigned, 3x3/5b signed,
// 4x4/8b unsigned) share clock and reset; a plain matrix-multiply model
// with tile accumulation provides every expected result.
module tb_mac_systolic_mm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_systolic_mm_if #(.N(3), .DW(5), .ACC_W(14)) if0 ();
    mac_systolic_mm_if #(.N(3), .DW(5), .ACC_W(14)) if1 ();
    mac_systolic_mm_if #(.N(4), .DW(8), .ACC_W(20)) if2 ();

    mac_systolic_mm #(.N(3), .DW(5), .ACC_W(14), .SIGNED(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mac_systolic_mm #(.N(3), .DW(5), .ACC_W(14), .SIGNED(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mac_systolic_mm #(.N(4), .DW(8), .ACC_W(20), .SIGNED(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    typedef struct {
        int     d;
        int     ak, av, bk, bv;   // kind: 0 = all val, 1 = val*identity, 2 = 1..n*n row-major
        bit     keep;
        int     ek;               // 0 = every element ev, 1 = equals 1..n*n, 2 = identity
        longint ev;
    } vec_t;

    int     am[4][4], bm[4][4];
    longint cref[3][4][4];
    longint cap[4][4];
    int     n_chk = 0, n_fail = 0;
    bit     s_ir, s_ov, s_last, s_busy;
    int     s_row;
    longint s_c[4];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic samp(input int d);
        case (d)
            0: begin
                s_ir = if0.in_ready; s_ov = if0.out_valid; s_row = int'(if0.out_row);
                s_last = if0.out_last; s_busy = if0.busy;
                for (int j = 0; j < 3; j++) s_c[j] = longint'(if0.c_row[j]);
            end
            1: begin
                s_ir = if1.in_ready; s_ov = if1.out_valid; s_row = int'(if1.out_row);
                s_last = if1.out_last; s_busy = if1.busy;
                for (int j = 0; j < 3; j++) s_c[j] = longint'(if1.c_row[j]);
            end
            default: begin
                s_ir = if2.in_ready; s_ov = if2.out_valid; s_row = int'(if2.out_row);
                s_last = if2.out_last; s_busy = if2.busy;
                for (int j = 0; j < 4; j++) s_c[j] = longint'(if2.c_row[j]);
            end
        endcase
    endtask

    task automatic drv(input int d, input bit v, input int k, input bit kb, input bit jk);
        case (d)
            0: begin
                if0.in_valid = v; if0.acc_keep = kb;
                for (int i = 0; i < 3; i++) begin
                    if0.a_col[i] = jk ? 5'($urandom) : 5'(am[i][k]);
                    if0.b_row[i] = jk ? 5'($urandom) : 5'(bm[k][i]);
                end
            end
            1: begin
                if1.in_valid = v; if1.acc_keep = kb;
                for (int i = 0; i < 3; i++) begin
                    if1.a_col[i] = jk ? 5'($urandom) : 5'(am[i][k]);
                    if1.b_row[i] = jk ? 5'($urandom) : 5'(bm[k][i]);
                end
            end
            default: begin
                if2.in_valid = v; if2.acc_keep = kb;
                for (int i = 0; i < 4; i++) begin
                    if2.a_col[i] = jk ? 8'($urandom) : 8'(am[i][k]);
                    if2.b_row[i] = jk ? 8'($urandom) : 8'(bm[k][i]);
                end
            end
        endcase
    endtask

    task automatic setrdy(input int d, input bit v);
        case (d)
            0: if0.out_ready = v;
            1: if1.out_ready = v;
            default: if2.out_ready = v;
        endcase
    endtask

    task automatic fill(input int n, input int ak, input int av, input int bk, input int bv);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                am[i][j] = (ak == 0) ? av : (ak == 1) ? ((i == j) ? av : 0) : i*n + j + 1;
                bm[i][j] = (bk == 0) ? bv : (bk == 1) ? ((i == j) ? bv : 0) : i*n + j + 1;
            end
    endtask

    // Feed one tile (vmask bit g = in_valid in cycle g of the load phase),
    // then drain it, stalling out_ready on stall_row for stall_cyc cycles.
    // jk drives junk operands and random out_ready while the engine must ignore them.
    task automatic run_tile(input int d, input bit keep, input bit [31:0] vmask,
                            input int stall_row, input int stall_cyc, input bit jk);
        int n, k, g, lat, bad, hrow;
        bit v, acc;
        longint m, sum, held[4];
        n = (d == 2) ? 4 : 3;
        m = (d == 2) ? (64'd1 << 20) - 1 : (64'd1 << 14) - 1;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                sum = 0;
                for (int kk = 0; kk < n; kk++) sum += longint'(am[i][kk]) * longint'(bm[kk][j]);
                cref[d][i][j] = keep ? cref[d][i][j] + sum : sum;
            end
        g = 0;
        samp(d);
        while (!s_ir && g < 20) begin
            @(posedge clk); #1; samp(d); g++;
        end
        chk("idle_in_ready", s_ir, 1);
        k = 0; g = 0;
        while (k < n && g < 200) begin
            v = (g < 32) ? vmask[g] : 1'b1;
            drv(d, v, k, (v && k == 0) ? keep : 1'($urandom), !v);
            samp(d);
            acc = v && s_ir;
            @(posedge clk); #1;
            if (acc) k++;
            g++;
        end
        drv(d, jk, 0, 1'($urandom), 1'b1);
        lat = 1; bad = 0;
        samp(d);
        while (!s_ov && lat < 100) begin
            if (s_ir || !s_busy) bad++;
            if (jk) setrdy(d, 1'($urandom));
            @(posedge clk); #1; lat++;
            samp(d);
        end
        chk("first_out_latency", lat, 2*n);
        chk("flush_in_ready_low", bad, 0);
        for (int r = 0; r < n; r++) begin
            samp(d);
            if (r == stall_row && stall_cyc > 0) begin
                setrdy(d, 1'b0);
                hrow = s_row; bad = 0;
                for (int j = 0; j < n; j++) held[j] = s_c[j];
                repeat (stall_cyc) begin
                    @(posedge clk); #1; samp(d);
                    if (s_row != hrow || !s_ov || s_ir) bad++;
                    for (int j = 0; j < n; j++) if (s_c[j] != held[j]) bad++;
                end
                chk("stall_hold", bad, 0);
            end
            if (r == n-1) drv(d, 1'b0, 0, 1'b0, 1'b0);
            setrdy(d, 1'b1);
            chk("out_valid", s_ov, 1);
            chk("out_row", s_row, r);
            chk("out_last", s_last, (r == n-1));
            chk("out_in_ready_low", s_ir, 0);
            for (int j = 0; j < n; j++) begin
                cap[r][j] = s_c[j];
                chk("c_elem", s_c[j], cref[d][r][j] & m);
            end
            @(posedge clk); #1;
        end
        setrdy(d, 1'b0);
        samp(d);
        chk("done_out_valid", s_ov, 0);
        chk("done_busy", s_busy, 0);
    endtask

    task automatic chk_cap(input string nm, input int n, input int ek, input longint ev);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                chk(nm, cap[i][j], (ek == 0) ? ev : (ek == 1) ? longint'(i*n + j + 1) : longint'(i == j));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int d;
        tbl[0] = '{d:0, ak:0, av:31,  bk:0, bv:31,  keep:0, ek:0, ev:2883};
        tbl[1] = '{d:0, ak:0, av:31,  bk:0, bv:31,  keep:1, ek:0, ev:5766};
        tbl[2] = '{d:1, ak:0, av:-16, bk:0, bv:-16, keep:0, ek:0, ev:768};
        tbl[3] = '{d:1, ak:1, av:-1,  bk:0, bv:15,  keep:0, ek:0, ev:16369};
        tbl[4] = '{d:2, ak:0, av:255, bk:0, bv:255, keep:0, ek:0, ev:260100};
        tbl[5] = '{d:0, ak:1, av:1,   bk:2, bv:0,   keep:0, ek:1, ev:0};

        for (int dd = 0; dd < 3; dd++) begin
            drv(dd, 1'b0, 0, 1'b0, 1'b0);
            setrdy(dd, 1'b0);
        end
        cref = '{default: '{default: '{default: 0}}};

        repeat (3) @(posedge clk);
        #1;
        for (int dd = 0; dd < 3; dd++) begin
            samp(dd);
            chk("rst_out_valid", s_ov, 0);
            chk("rst_out_last", s_last, 0);
            chk("rst_out_row", s_row, 0);
            chk("rst_busy", s_busy, 0);
            chk("rst_in_ready", s_ir, 0);
            chk("rst_c_row0", s_c[0], 0);
        end
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++) begin
            fill((tbl[t].d == 2) ? 4 : 3, tbl[t].ak, tbl[t].av, tbl[t].bk, tbl[t].bv);
            run_tile(tbl[t].d, tbl[t].keep, 32'hFFFF_FFFF, -1, 0, 1'b0);
            chk_cap("tbl_elem", (tbl[t].d == 2) ? 4 : 3, tbl[t].ek, tbl[t].ev);
        end

        // Gapped beats (1-0-0-1-0-1), row 1 stalled for 3 cycles, junk while busy.
        fill(3, 1, 1, 2, 0);
        run_tile(0, 1'b0, 32'hFFFF_FFE9, 1, 3, 1'b1);
        chk_cap("gap_elem", 3, 1, 0);

        // Reset two steps into FLUSH: outputs clear at once, no residue afterwards.
        fill(3, 0, 7, 0, 9);
        for (int k = 0; k < 3; k++) begin
            drv(0, 1'b1, k, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        drv(0, 1'b0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        samp(0);
        chk("mid_flush_busy", s_busy, 1);
        rst_n = 1'b0;
        #1;
        samp(0);
        chk("arst_busy", s_busy, 0);
        chk("arst_in_ready", s_ir, 0);
        chk("arst_out_valid", s_ov, 0);
        chk("arst_out_row", s_row, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cref = '{default: '{default: '{default: 0}}};
        fill(3, 1, 1, 1, 1);
        run_tile(0, 1'b1, 32'hFFFF_FFFF, -1, 0, 1'b0);
        chk_cap("post_rst_ident", 3, 2, 0);

        for (int t = 0; t < 12; t++) begin
            d = t % 3;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    am[i][j] = (d == 0) ? int'($urandom_range(31)) :
                               (d == 1) ? int'($urandom_range(31)) - 16 : int'($urandom_range(255));
                    bm[i][j] = (d == 0) ? int'($urandom_range(31)) :
                               (d == 1) ? int'($urandom_range(31)) - 16 : int'($urandom_range(255));
                end
            run_tile(d, 1'($urandom), $urandom, int'($urandom_range(3)), int'($urandom_range(3)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_systolic_mm.md
Name: mac_systolic_mm

Overview:
- Parametrised N×N output-stationary systolic matrix-multiply engine. Computes C = A·B for N×N operand tiles with DW-bit elements.
- Successor to the fixed 3×3 / 5-bit systolic multiplier. Adds valid/ready streaming, internal operand skewing, signed mode, tile accumulation and row-serial result drain.
- Sits between the operand fetch stage and the result writeback stage.

Parameters:
- N, 3, array dimension (tile is N×N); N ≥ 2.
- DW, 5, operand element width.
- ACC_W, 2*DW+4, accumulator and result element width; must be ≥ 2*DW+clog2(N) for overflow-free results.
- SIGNED, 0, 1 = two's-complement operands and accumulation; 0 = unsigned.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  engine accepts a beat.
- a_col  in  N*DW  column k of A; element i at bits [i*DW +: DW].
- b_row  in  N*DW  row k of B; element j at bits [j*DW +: DW].
- acc_keep  in  1  sampled with beat k=0 only; 1 = add the tile onto the existing C, 0 = clear C first.
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts a row.
- c_row  out  N*ACC_W  row r of C; element j at bits [j*ACC_W +: ACC_W].
- out_row  out  clog2(N)  index r of the presented row.
- out_last  out  1  high with row N-1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state=IDLE.
  - All accumulators, skew registers, beat/step/row counters = 0.
  - out_valid=0, out_last=0, out_row=0, c_row=0, busy=0, in_ready=0.
- After reset deassertion, in_ready=1.
- Reset mid-operation aborts the tile with no partial output.
- FSM states: IDLE, LOAD, FLUSH, OUT.
- IDLE:
  - in_ready=1.
  - An accepted beat (in_valid & in_ready) is beat k=0 and moves the FSM to LOAD.
  - On beat 0, accumulators clear if acc_keep=0 and are preserved if acc_keep=1. The clear and the first MAC step happen together.
- LOAD:
  - in_ready=1.
  - Each accepted beat is one array step.
  - Cycles with in_valid=0 freeze the whole array, skew registers included. Gaps therefore never corrupt results.
  - After beat N-1 is accepted, go to FLUSH.
- FLUSH:
  - in_ready=0.
  - The array steps every cycle with zero operands injected, for exactly 2N-1 steps.
  - Then go to OUT with r=0.
- Skew:
  - A element i is delayed i steps; B element j is delayed j steps.
  - PE(i,j) adds a[i][k]·b[k][j] at step k+i+j+1.
  - The last product lands at step 3N-2, inside N + 2N-1 steps.
- OUT:
  - out_valid=1; c_row = accumulator row r, registered.
  - On out_valid & out_ready: r increments; after r=N-1, go to IDLE.
  - With out_ready=0, c_row, out_row and out_last hold stable.
  - in_ready=0 throughout OUT.
  - Accumulators are not cleared on drain, so acc_keep works across tiles.
- Latency: first out_valid occurs exactly 2N cycles after the cycle in which beat N-1 is accepted.
- Arithmetic:
  - Product width is 2*DW. It is sign-extended (SIGNED=1) or zero-extended to ACC_W before adding.
  - Accumulation wraps modulo 2^ACC_W; there is no saturation.
- Inputs are ignored while in_ready=0. out_ready is ignored while out_valid=0.
- acc_keep is ignored for beats k>0.

Decomposition:
- Package mac_pkg:
  - state enum {IDLE, LOAD, FLUSH, OUT}.
  - Width helpers: CNT_W = clog2(3N), ROW_W = clog2(N).
  - Default-parameter constants.
- Sub-module mac_pe:
  - Ports: clk, rst_n, step_en, clr, a_in, b_in, a_out, b_out, acc.
  - Registered pass-through of a and b, with a MAC into acc.
  - Top level instantiates N×N mac_pe via generate, plus triangular skew register banks.

Test Plan:
- N=3, DW=5, SIGNED=0, A=identity, B=[[1..9]], acc_keep=0, continuous beats -> rows {1,2,3},{4,5,6},{7,8,9}; out_valid exactly 6 cycles after beat 2; out_last on row 2.
- All elements 31, acc_keep=0 -> every C element 2883. Repeat the same tile with acc_keep=1 -> every element 5766.
- SIGNED=1, all elements -16 (5'b10000) -> every C element +768. A=-1·identity, B all 15 -> every element -15 (14'h3FF1).
- Backpressure/gaps: in_valid toggles 1-0-0-1-0-1 and out_ready low for 3 cycles on row 1 -> same results as the first scenario; c_row/out_row stable while stalled; in_ready=0 during FLUSH/OUT.
- Reset: rst_n pulsed low for 1 cycle mid-FLUSH -> all outputs 0 and state IDLE. A fresh identity×identity tile then yields an identity result with no residue.
- N=4, DW=8, SIGNED=0, all 255, acc_keep=0 -> every element 260100; first out_valid 8 cycles after beat 3.
